irq_vector_seq: RTL and testbench
=================================

Name: irq_vector_seq

Overview:
- Hardware interrupt-vectoring sequencer placed between the SoC interrupt controller's AXI4-Lite config port and the CPU.
- On a level interrupt, it reads the vector register (IVR), presents the vector to the CPU, and waits for end-of-interrupt.
- It then writes the one-hot acknowledge (IAR) and enforces a hold-off before re-arming.
- This removes the IVR read and IAR write from the software ISR prologue and epilogue.

Parameters:
- BASE_ADDR, 32'h0000_0000, base address of the interrupt controller config window.
- IVR_OFFSET, 8'h18, byte offset of the vector register.
- IAR_OFFSET, 8'h0C, byte offset of the acknowledge register.
- N_IRQ, 4, number of interrupt lines; legal vectors are 0..N_IRQ-1.
- HOLDOFF, 2, idle cycles after the IAR write response before irq_i is sampled again (covers the registered pending/intr path).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low (asserted at 0)
- irq_i  in  1  level interrupt from the controller's intr output
- m_awvalid_o  out  1  / m_awready_i  in  1  / m_awaddr_o  out  32  write address channel
- m_wvalid_o  out  1  / m_wready_i  in  1  / m_wdata_o  out  32  / m_wstrb_o  out  4  write data channel
- m_bvalid_i  in  1  / m_bready_o  out  1  / m_bresp_i  in  2  write response channel
- m_arvalid_o  out  1  / m_arready_i  in  1  / m_araddr_o  out  32  read address channel
- m_rvalid_i  in  1  / m_rready_o  out  1  / m_rdata_i  in  32  / m_rresp_i  in  2  read data channel
- vec_valid_o  out  1  vector available to CPU
- vec_o  out  32  captured vector
- vec_ready_i  in  1  CPU accepts vector
- eoi_i  in  1  CPU end-of-interrupt pulse
- busy_o  out  1  FSM not in IDLE
- err_o  out  1  sticky error flag
- err_clr_i  in  1  clears err_o
- stat_served_o  out  16  serviced interrupt count (optional feature)
- stat_spurious_o  out  16  spurious read count (optional feature)

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All outputs are 0, including vec_o, counters and err_o.
  - FSM goes to IDLE. Any in-flight bus transaction is abandoned.
- FSM states: IDLE, RD_A, RD_D, PRESENT, SERVICE, WR, WR_B, HOLD.
- IDLE: when irq_i=1, go to RD_A next cycle.
- RD_A:
  - m_arvalid_o=1, m_araddr_o=BASE_ADDR+IVR_OFFSET.
  - Hold both until m_arready_i=1, then go to RD_D.
- RD_D:
  - m_rready_o=1. On m_rvalid_i, capture m_rdata_i into vec_o.
  - If m_rresp_i!=0: set err_o, go to HOLD.
  - If m_rdata_i==32'hFFFF_FFFF (spurious): increment spurious count, go to HOLD.
  - If m_rdata_i>=N_IRQ: set err_o, go to HOLD.
  - Otherwise go to PRESENT.
- PRESENT: vec_valid_o=1 until vec_ready_i=1 (same-cycle accept allowed), then go to SERVICE.
- SERVICE: wait for eoi_i. An eoi_i in any other state is ignored.
- WR:
  - Assert m_awvalid_o and m_wvalid_o in the same cycle.
  - m_awaddr_o=BASE_ADDR+IAR_OFFSET, m_wdata_o=1<<vec_o, m_wstrb_o=4'hF.
  - Each valid deasserts independently on its own ready. Handshakes may complete in either order or together.
  - m_bready_o=1 from WR entry until the response.
  - Go to WR_B once both handshakes are done.
- WR_B:
  - On m_bvalid_i: if m_bresp_i!=0, set err_o; otherwise increment served count.
  - Go to HOLD.
- HOLD:
  - Count HOLDOFF cycles, then go to IDLE. irq_i is ignored during HOLD.
  - HOLDOFF=0 means HOLD lasts exactly 1 cycle.
- AXI rules: address, data and strobe are stable while their valid is high. No valid waits on a ready.
- err_o: err_clr_i clears it. If a set and a clear occur in the same cycle, the set wins.
- Counters: 16-bit, wrap from FFFF to 0000.
- vec_o: holds its value until the next RD_D capture.
- busy_o = (state!=IDLE).

Optional Feature:
- Macro: IRQ_VECTOR_SEQ_STATS_EN.
- Defined: stat_served_o and stat_spurious_o count as specified above.
- Undefined: the counters are not built and both outputs are tied to 0. All other behaviour is identical.

Test Plan:
- Basic service:
  - Stimulus: irq_i=1; slave returns rdata=2, rresp=0; CPU asserts vec_ready_i, then eoi_i.
  - Required: vec_o=2; IAR write addr=BASE+0x0C, wdata=32'h4, wstrb=F; served count=1; IDLE after HOLD of exactly 2 cycles.
- Spurious:
  - Stimulus: read returns rdata=32'hFFFF_FFFF.
  - Required: no vec_valid_o and no write; spurious count=1; return to IDLE after HOLD.
- Backpressure:
  - Stimulus: arready delayed 3 cycles; wready 2 cycles before awready; bvalid delayed 4 cycles.
  - Required: valids and addresses stable throughout; exactly one read and one write issued.
- Errors:
  - Stimulus 1: rresp=2'b10. Required: err_o=1, no presentation.
  - Stimulus 2: bresp=2'b10. Required: err_o=1, served count unchanged.
  - Stimulus 3: err_clr_i pulse. Required: err_o=0.
  - Stimulus 4: rdata=5 with N_IRQ=4. Required: err_o=1.
- Reset mid-operation:
  - Stimulus: rst_i=0 while in WR with m_awvalid_o=1.
  - Required: all outputs 0 asynchronously; IDLE after release.
  - Stimulus: stray eoi_i while in IDLE. Required: ignored.
- Back-to-back interrupts:
  - Stimulus: irq_i held high across two services (vectors 0 then 3).
  - Required: the second IVR read starts only after HOLD completes; wdata values 32'h1 then 32'h8.

Source files
------------

// File: rtl/irq_vector_seq.sv
// ---------------------------------------------------------------------------
// irq_vector_seq
//
// Hardware interrupt-vectoring sequencer. It sits between the interrupt
// controller's AXI4-Lite config port and the CPU. On a level interrupt it
// reads the vector register (IVR), presents the vector to the CPU, and waits
// for end-of-interrupt. It then writes the one-hot acknowledge (IAR) and waits
// out a hold-off before it re-arms.
//
// Optional feature macro: IRQ_VECTOR_SEQ_STATS_EN
//   defined   -> stat_served_o / stat_spurious_o are live 16-bit wrapping counters
//   undefined -> counters are not built and both outputs are tied to 0
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   irq_i                   level interrupt from the controller
//   m_aw*/m_w*/m_b*         AXI4-Lite write address / data / response (master)
//   m_ar*/m_r*              AXI4-Lite read address / data (master)
//   vec_valid_o, vec_o      vector offered to the CPU, captured vector
//   vec_ready_i             CPU accepts the vector
//   eoi_i                   CPU end-of-interrupt pulse (honoured only in SERVICE)
//   busy_o                  sequencer not idle
//   err_o, err_clr_i        sticky error flag and its clear (set wins)
//   stat_served_o           serviced interrupt count
//   stat_spurious_o         spurious vector read count
//   dbg_state_o             current FSM state, for debug and checkers
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Every valid is driven from state and completion flags only,
// never from a ready, and address/data/strobe are constant while their valid
// is high. Once raised, a valid stays high until its own handshake completes.
// ---------------------------------------------------------------------------
module irq_vector_seq #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [7:0]  IVR_OFFSET = 8'h18,
  parameter logic [7:0]  IAR_OFFSET = 8'h0C,
  parameter int          N_IRQ      = 4,
  parameter int          HOLDOFF    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_i,
  output logic        m_awvalid_o,
  input  logic        m_awready_i,
  output logic [31:0] m_awaddr_o,
  output logic        m_wvalid_o,
  input  logic        m_wready_i,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  input  logic        m_bvalid_i,
  output logic        m_bready_o,
  input  logic [1:0]  m_bresp_i,
  output logic        m_arvalid_o,
  input  logic        m_arready_i,
  output logic [31:0] m_araddr_o,
  input  logic        m_rvalid_i,
  output logic        m_rready_o,
  input  logic [31:0] m_rdata_i,
  input  logic [1:0]  m_rresp_i,
  output logic        vec_valid_o,
  output logic [31:0] vec_o,
  input  logic        vec_ready_i,
  input  logic        eoi_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [15:0] stat_served_o,
  output logic [15:0] stat_spurious_o,
  output logic [2:0]  dbg_state_o
);

  localparam logic [31:0] IVR_ADDR = BASE_ADDR + {24'h0, IVR_OFFSET};
  localparam logic [31:0] IAR_ADDR = BASE_ADDR + {24'h0, IAR_OFFSET};

  // A zero hold-off still spends one cycle in HOLD.
  localparam int HOLD_LEN = (HOLDOFF == 0) ? 1 : HOLDOFF;
  localparam int HW       = $clog2(HOLD_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_A    = 3'd1,
    S_RD_D    = 3'd2,
    S_PRESENT = 3'd3,
    S_SERVICE = 3'd4,
    S_WR      = 3'd5,
    S_WR_B    = 3'd6,
    S_HOLD    = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_vec;
  logic            r_aw_done;
  logic            r_w_done;
  logic            r_err;
  logic [HW-1:0]   r_hold_cnt;
  logic            w_err_set;
  logic            w_hold_last;
  logic            w_aw_ok;
  logic            w_w_ok;

  assign w_hold_last = (r_hold_cnt == HW'(HOLD_LEN - 1));
  // Each write channel is complete if it finished earlier or finishes now.
  assign w_aw_ok     = r_aw_done | m_awready_i;
  assign w_w_ok      = r_w_done  | m_wready_i;

  // Next-state and error-set decode.
  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE:    if (irq_i) w_next = S_RD_A;
      S_RD_A:    if (m_arready_i) w_next = S_RD_D;
      S_RD_D: begin
        if (m_rvalid_i) begin
          if (m_rresp_i != 2'b00) begin
            w_err_set = 1'b1;
            w_next    = S_HOLD;
          end else if (m_rdata_i == 32'hFFFF_FFFF) begin
            w_next = S_HOLD;
          end else if (m_rdata_i >= 32'(N_IRQ)) begin
            w_err_set = 1'b1;
            w_next    = S_HOLD;
          end else begin
            w_next = S_PRESENT;
          end
        end
      end
      S_PRESENT: if (vec_ready_i) w_next = S_SERVICE;
      S_SERVICE: if (eoi_i) w_next = S_WR;
      S_WR:      if (w_aw_ok && w_w_ok) w_next = S_WR_B;
      S_WR_B: begin
        if (m_bvalid_i) begin
          w_err_set = (m_bresp_i != 2'b00);
          w_next    = S_HOLD;
        end
      end
      S_HOLD:    if (w_hold_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_vec      <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_err      <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RD_D && m_rvalid_i) begin
        r_vec <= m_rdata_i;
      end
      // Completion flags live only inside WR; they are cleared everywhere else
      // so the next write starts with both valids raised.
      if (r_state == S_WR) begin
        if (m_awvalid_o && m_awready_i) r_aw_done <= 1'b1;
        if (m_wvalid_o && m_wready_i)   r_w_done  <= 1'b1;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == S_HOLD) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end else begin
        r_hold_cnt <= '0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

  // Bus outputs are zero whenever their valid is low, so reset drives all 0.
  assign m_arvalid_o = (r_state == S_RD_A);
  assign m_araddr_o  = m_arvalid_o ? IVR_ADDR : 32'h0;
  assign m_rready_o  = (r_state == S_RD_D);
  assign m_awvalid_o = (r_state == S_WR) && !r_aw_done;
  assign m_awaddr_o  = m_awvalid_o ? IAR_ADDR : 32'h0;
  assign m_wvalid_o  = (r_state == S_WR) && !r_w_done;
  assign m_wdata_o   = m_wvalid_o ? (32'd1 << r_vec) : 32'h0;
  assign m_wstrb_o   = m_wvalid_o ? 4'hF : 4'h0;
  assign m_bready_o  = (r_state == S_WR) || (r_state == S_WR_B);
  assign vec_valid_o = (r_state == S_PRESENT);
  assign vec_o       = r_vec;
  assign busy_o      = (r_state != S_IDLE);
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

`ifdef IRQ_VECTOR_SEQ_STATS_EN
  logic [15:0] r_served;
  logic [15:0] r_spurious;
  logic        w_served_inc;
  logic        w_spur_inc;

  assign w_served_inc = (r_state == S_WR_B) && m_bvalid_i && (m_bresp_i == 2'b00);
  assign w_spur_inc   = (r_state == S_RD_D) && m_rvalid_i && (m_rresp_i == 2'b00) &&
                        (m_rdata_i == 32'hFFFF_FFFF);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_served   <= '0;
      r_spurious <= '0;
    end else begin
      if (w_served_inc) r_served   <= r_served + 16'd1;
      if (w_spur_inc)   r_spurious <= r_spurious + 16'd1;
    end
  end

  assign stat_served_o   = r_served;
  assign stat_spurious_o = r_spurious;
`else
  assign stat_served_o   = 16'h0;
  assign stat_spurious_o = 16'h0;
`endif

endmodule

// File: tb/tb_irq_vector_seq.sv
// ---------------------------------------------------------------------------
// tb_irq_vector_seq
//
// Directed and randomized bench for irq_vector_seq. The bench plays both the
// AXI4-Lite slave and the CPU. A small transaction-level model (error flag,
// served/spurious counts, expected read/write totals) gives every expected
// value; bus monitors count handshakes independently of the stimulus.
// ---------------------------------------------------------------------------
module tb_irq_vector_seq;

  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam logic [31:0] IVR_A   = BASE + 32'h18;
  localparam logic [31:0] IAR_A   = BASE + 32'h0C;
  localparam int          N_IRQ   = 4;
  localparam int          HOLDOFF = 2;
`ifdef IRQ_VECTOR_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        irq_i = 1'b0;
  logic        m_awvalid_o, m_awready_i = 1'b0;
  logic [31:0] m_awaddr_o;
  logic        m_wvalid_o, m_wready_i = 1'b0;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        m_bvalid_i = 1'b0, m_bready_o;
  logic [1:0]  m_bresp_i = 2'b00;
  logic        m_arvalid_o, m_arready_i = 1'b0;
  logic [31:0] m_araddr_o;
  logic        m_rvalid_i = 1'b0, m_rready_o;
  logic [31:0] m_rdata_i = 32'h0;
  logic [1:0]  m_rresp_i = 2'b00;
  logic        vec_valid_o;
  logic [31:0] vec_o;
  logic        vec_ready_i = 1'b0;
  logic        eoi_i = 1'b0;
  logic        busy_o, err_o;
  logic        err_clr_i = 1'b0;
  logic [15:0] stat_served_o, stat_spurious_o;
  logic [2:0]  dbg_state_o;

  irq_vector_seq #(
    .BASE_ADDR(BASE), .IVR_OFFSET(8'h18), .IAR_OFFSET(8'h0C),
    .N_IRQ(N_IRQ), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i),
    .vec_valid_o(vec_valid_o), .vec_o(vec_o), .vec_ready_i(vec_ready_i),
    .eoi_i(eoi_i), .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .stat_served_o(stat_served_o), .stat_spurious_o(stat_spurious_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic m_err  = 1'b0;
  int m_served = 0;
  int m_spur   = 0;
  int m_reads  = 0;
  int m_writes = 0;
  int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      if (m_arvalid_o && m_arready_i) n_ar++;
      if (m_awvalid_o && m_awready_i) n_aw++;
      if (m_wvalid_o  && m_wready_i)  n_w++;
      if (m_bvalid_i  && m_bready_o)  n_b++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] exp_served();
    return STATS ? 32'(m_served % 65536) : 32'h0;
  endfunction

  function automatic logic [31:0] exp_spur();
    return STATS ? 32'(m_spur % 65536) : 32'h0;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_arvalid"}, 32'(m_arvalid_o), 0);
    chk({tag, "_araddr"},  m_araddr_o, 0);
    chk({tag, "_rready"},  32'(m_rready_o), 0);
    chk({tag, "_awvalid"}, 32'(m_awvalid_o), 0);
    chk({tag, "_awaddr"},  m_awaddr_o, 0);
    chk({tag, "_wvalid"},  32'(m_wvalid_o), 0);
    chk({tag, "_wdata"},   m_wdata_o, 0);
    chk({tag, "_wstrb"},   32'(m_wstrb_o), 0);
    chk({tag, "_bready"},  32'(m_bready_o), 0);
    chk({tag, "_vvalid"},  32'(vec_valid_o), 0);
    chk({tag, "_vec"},     vec_o, 0);
    chk({tag, "_busy"},    32'(busy_o), 0);
    chk({tag, "_err"},     32'(err_o), 0);
    chk({tag, "_served"},  32'(stat_served_o), 0);
    chk({tag, "_spur"},    32'(stat_spurious_o), 0);
    chk({tag, "_dbg"},     32'(dbg_state_o), 0);
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    m_err = 1'b0;
    chk("err_clear", 32'(err_o), 0);
  endtask

  // One complete interrupt from IVR read to end of hold-off.
  task automatic serve(input logic [31:0] rdata, input logic [1:0] rresp,
                       input logic [1:0] bresp, input int ar_dly, input int r_dly,
                       input int vr_dly, input int eoi_dly, input int aw_dly,
                       input int w_dly, input int b_dly, input bit keep_irq,
                       input bit clr_with_set);
    int  cnt;
    int  kmax;
    bit  present;
    bit  set_err;
    logic [31:0] exp_wdata;
    irq_i = 1'b1;
    cnt = 0;
    while (!m_arvalid_o && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("ar_start", 32'(m_arvalid_o), 1);
    for (int i = 0; i < ar_dly; i++) begin
      chk("ar_hold", 32'(m_arvalid_o), 1);
      chk("ar_addr_hold", m_araddr_o, IVR_A);
      tick();
    end
    chk("ar_addr", m_araddr_o, IVR_A);
    m_arready_i = 1'b1;
    tick();
    m_arready_i = 1'b0;
    m_reads++;
    for (int i = 0; i < r_dly; i++) begin
      chk("rready", 32'(m_rready_o), 1);
      chk("ar_dropped", 32'(m_arvalid_o), 0);
      tick();
    end
    chk("rready", 32'(m_rready_o), 1);
    m_rvalid_i = 1'b1;
    m_rdata_i  = rdata;
    m_rresp_i  = rresp;
    err_clr_i  = clr_with_set;
    tick();
    m_rvalid_i = 1'b0;
    m_rresp_i  = 2'b00;
    err_clr_i  = 1'b0;
    m_rdata_i  = $urandom;
    chk("vec_capture", vec_o, rdata);

    present = 1'b0;
    set_err = 1'b0;
    if (rresp != 2'b00)              set_err = 1'b1;
    else if (rdata == 32'hFFFF_FFFF) m_spur++;
    else if (rdata >= 32'(N_IRQ))    set_err = 1'b1;
    else                             present = 1'b1;
    if (set_err)           m_err = 1'b1;
    else if (clr_with_set) m_err = 1'b0;
    chk("err_after_read", 32'(err_o), 32'(m_err));

    if (present) begin
      chk("vec_valid", 32'(vec_valid_o), 1);
      for (int i = 0; i < vr_dly; i++) begin
        chk("vec_valid_hold", 32'(vec_valid_o), 1);
        chk("vec_hold", vec_o, rdata);
        tick();
      end
      vec_ready_i = 1'b1;
      tick();
      vec_ready_i = 1'b0;
      chk("vec_taken", 32'(vec_valid_o), 0);
      chk("service_busy", 32'(busy_o), 1);
      for (int i = 0; i < eoi_dly; i++) begin
        chk("no_early_aw", 32'(m_awvalid_o), 0);
        tick();
      end
      eoi_i = 1'b1;
      tick();
      eoi_i = 1'b0;
      exp_wdata = 32'h1 << rdata[4:0];
      kmax = (aw_dly > w_dly) ? aw_dly : w_dly;
      for (int k = 0; k <= kmax; k++) begin
        chk("awvalid", 32'(m_awvalid_o), 32'(k <= aw_dly));
        if (k <= aw_dly) chk("awaddr", m_awaddr_o, IAR_A);
        chk("wvalid", 32'(m_wvalid_o), 32'(k <= w_dly));
        if (k <= w_dly) begin
          chk("wdata", m_wdata_o, exp_wdata);
          chk("wstrb", 32'(m_wstrb_o), 32'hF);
        end
        chk("bready_wr", 32'(m_bready_o), 1);
        m_awready_i = (k == aw_dly);
        m_wready_i  = (k == w_dly);
        tick();
      end
      m_awready_i = 1'b0;
      m_wready_i  = 1'b0;
      m_writes++;
      for (int i = 0; i < b_dly; i++) begin
        chk("bready_wait", 32'(m_bready_o), 1);
        chk("aw_done", 32'(m_awvalid_o), 0);
        chk("w_done", 32'(m_wvalid_o), 0);
        tick();
      end
      chk("bready", 32'(m_bready_o), 1);
      m_bvalid_i = 1'b1;
      m_bresp_i  = bresp;
      tick();
      m_bvalid_i = 1'b0;
      m_bresp_i  = 2'b00;
      if (bresp != 2'b00) m_err = 1'b1;
      else                m_served++;
      chk("err_after_write", 32'(err_o), 32'(m_err));
    end else begin
      chk("no_present", 32'(vec_valid_o), 0);
      chk("no_write", 32'(m_awvalid_o), 0);
    end

    if (!keep_irq) irq_i = 1'b0;
    for (int i = 0; i < HOLDOFF; i++) begin
      chk("hold_busy", 32'(busy_o), 1);
      chk("hold_no_ar", 32'(m_arvalid_o), 0);
      tick();
    end
    chk("hold_end_idle", 32'(busy_o), 0);
    chk("vec_kept", vec_o, rdata);
    chk("stat_served", 32'(stat_served_o), exp_served());
    chk("stat_spur", 32'(stat_spurious_o), exp_spur());
    tick();
    if (keep_irq) chk("rearm_ar", 32'(m_arvalid_o), 1);
    else          chk("stay_idle", 32'(busy_o), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;
    int          cat;
    int          cnt;

    rst_i = 1'b0;
    tick(); tick(); tick();
    check_all_zero("reset");
    rst_i = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Stray end-of-interrupt while idle must do nothing.
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
    tick(); tick();
    chk("stray_eoi_busy", 32'(busy_o), 0);
    chk("stray_eoi_ar", 32'(m_arvalid_o), 0);

    // Basic service, vector 2.
    serve(32'd2, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 1'b0, 1'b0);
    // Spurious read.
    serve(32'hFFFF_FFFF, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    // Backpressure: arready late, wready two cycles before awready, bvalid late.
    serve(32'd1, 2'b00, 2'b00, 3, 2, 2, 2, 2, 0, 4, 1'b0, 1'b0);
    // Read response error.
    serve(32'd1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    pulse_clr();
    // Write response error: served count unchanged.
    serve(32'd3, 2'b00, 2'b10, 0, 0, 0, 0, 1, 1, 1, 1'b0, 1'b0);
    pulse_clr();
    // Out-of-range vector, with a clear in the same cycle as the set.
    serve(32'd5, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    pulse_clr();
    // Back-to-back with irq held: vectors 0 then 3.
    serve(32'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    serve(32'd3, 2'b00, 2'b00, 1, 0, 1, 0, 0, 1, 0, 1'b0, 1'b0);

    // Randomized services.
    for (int t = 0; t < 60; t++) begin
      cat = $urandom_range(0, 9);
      rr  = 2'b00;
      if (cat == 0)      rd = 32'hFFFF_FFFF;
      else if (cat == 1) begin rd = $urandom_range(0, 3); rr = 2'($urandom_range(1, 3)); end
      else if (cat == 2) rd = $urandom_range(4, 100000);
      else               rd = $urandom_range(0, N_IRQ - 1);
      br = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      serve(rd, rr, br, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 4), (t != 59) && ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 5) == 0));
      if (!irq_i && ($urandom_range(0, 4) == 0)) pulse_clr();
    end

    // Reset while the IAR write address is pending.
    irq_i = 1'b1;
    cnt = 0;
    while (!m_arvalid_o && cnt < 20) begin
      tick();
      cnt++;
    end
    m_arready_i = 1'b1;
    tick();
    m_arready_i = 1'b0;
    m_reads++;
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'd1;
    tick();
    m_rvalid_i  = 1'b0;
    vec_ready_i = 1'b1;
    tick();
    vec_ready_i = 1'b0;
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
    chk("wr_before_reset", 32'(m_awvalid_o), 1);
    #2;
    rst_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_err = 1'b0;
    m_served = 0;
    m_spur = 0;
    irq_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    tick();
    check_all_zero("after_release");

    // Normal service after reset.
    serve(32'd2, 2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 1'b0, 1'b0);

    chk("total_reads", 32'(n_ar), 32'(m_reads));
    chk("total_aw", 32'(n_aw), 32'(m_writes));
    chk("total_w", 32'(n_w), 32'(m_writes));
    chk("total_b", 32'(n_b), 32'(m_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
